result_stage: RTL and testbench
===============================

Name: result_stage

Overview:
- Writeback result stage of the multicycle RV32 core.
- Registers the ALU result and captures and aligns load data from the data memory port.
- Selects the value written back to the register file and to the PC.
- Parametrised successor of the basic ALU-out/data result mux. It adds a load-wait FSM with timeout, byte/halfword extraction, sign-extension, a registered-ALU enable and a fourth PC+4 source.

Parameters:
- WIDTH, 32, datapath width in bits; must be 32 when RESULT_LOAD_EXT_EN is defined.
- TIMEOUT, 15, maximum cycles spent in WAIT before aborting; 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_result  in  WIDTH  combinational ALU output
- alu_en  in  1  when 1, alu_out register captures alu_result
- pc_plus4  in  WIDTH  PC+4 for JAL/JALR link
- load_start  in  1  1-cycle request to begin a load
- load_funct3  in  3  load type, sampled with load_start
- load_addr_lo  in  2  address bits [1:0], sampled with load_start
- mem_rdata  in  WIDTH  memory read data
- mem_rvalid  in  1  mem_rdata valid this cycle
- result_sel  in  2  0 alu_out reg, 1 data reg, 2 alu_result, 3 pc_plus4
- result  out  WIDTH  selected writeback value
- load_busy  out  1  high while in WAIT
- load_done  out  1  1-cycle pulse: data reg updated
- load_err  out  1  1-cycle pulse: timeout or misaligned

Behaviour:
- Reset (rst_n low, asynchronous):
  - alu_out, data_reg, funct3/addr latches and counter all clear to 0.
  - FSM goes to IDLE.
  - load_busy, load_done, load_err are 0; result follows the mux using the cleared registers.
- alu_out: on posedge clk, if alu_en then alu_out <= alu_result; otherwise it holds.
- result: purely combinational mux per result_sel, zero-cycle latency. Select 1 returns data_reg.
- FSM states: IDLE, WAIT.
- IDLE:
  - load_start=1 latches funct3 and addr_lo, clears the counter and moves to WAIT.
  - If the request is misaligned, the FSM stays in IDLE instead and pulses load_err next cycle. Misaligned means halfword with addr_lo[0]=1, or word with addr_lo!=0.
- WAIT:
  - load_busy=1; the counter increments each cycle.
  - mem_rvalid=1: data_reg <= extracted value. load_done=1 in the following cycle. FSM returns to IDLE.
  - Counter reaches TIMEOUT without mem_rvalid: FSM returns to IDLE, data_reg holds, load_err pulses in the following cycle.
  - mem_rvalid and timeout in the same cycle: mem_rvalid wins.
  - load_start in WAIT is ignored.
- mem_rvalid in IDLE is ignored; data_reg is unchanged.
- load_done and load_err are never high together and are registered pulses.
- Extraction (RESULT_LOAD_EXT_EN defined):
  - Byte lane = mem_rdata[8*addr_lo +: 8].
  - Half lane = mem_rdata[16*addr_lo[1] +: 16].
  - funct3 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half.
  - 101 LHU: zero-extend half.
  - 010 LW and all other codes: full word.
- Reset asserted mid-WAIT: immediate return to IDLE with no load_done or load_err pulse.
- The counter is 8 bits and saturates; it never wraps.

Optional Feature:
- Macro: RESULT_LOAD_EXT_EN.
- Defined: byte/halfword extraction, sign/zero extension and misalignment detection as above.
- Undefined:
  - data_reg captures raw mem_rdata.
  - load_funct3 and load_addr_lo are ignored.
  - No misalignment errors; load_err comes only from timeout.
  - WIDTH may be any value of 8 or more.

Test Plan:
1. alu_en=1, alu_result=32'h0000_1234 for one cycle, then alu_result=32'hDEAD_BEEF with alu_en=0. Required: result_sel=0 gives 32'h0000_1234; result_sel=2 gives 32'hDEAD_BEEF; result_sel=3 gives pc_plus4.
2. load_start with funct3=000, addr_lo=2; mem_rvalid two cycles later with mem_rdata=32'h1280_FF34. Required: load_busy high for 2 cycles, load_done pulse, result_sel=1 gives 32'hFFFF_FF80. With funct3=100 the result is 32'h0000_0080.
3. load_start with funct3=001, addr_lo=2, mem_rdata=32'h8001_7FFF. Required: data_reg = 32'hFFFF_8001. Repeat with addr_lo=1: load_err pulse, load_busy stays 0, data_reg unchanged.
4. load_start, no mem_rvalid, TIMEOUT=15. Required: load_busy high for exactly 15 cycles, then a single load_err pulse and data_reg unchanged. Then mem_rvalid arriving in the TIMEOUT cycle gives load_done and no load_err.
5. rst_n dropped asynchronously mid-WAIT. Required: load_busy=0 immediately, no pulses, data_reg=0; a second load_start issued during WAIT is ignored.
6. Build without RESULT_LOAD_EXT_EN, funct3=000, mem_rdata=32'hCAFE_F00D. Required: data_reg = 32'hCAFE_F00D.

Source files
------------

// File: rtl/result_stage.sv
// -----------------------------------------------------------------------------
// result_stage
//
// Writeback result stage of the multicycle RV32 core. It registers the ALU
// result, waits for load data from the data memory port (with a timeout) and
// selects the value written back to the register file and to the PC.
//
// Optional feature macro: RESULT_LOAD_EXT_EN
//   defined   : byte/halfword lane extraction, sign/zero extension and
//               misalignment detection (WIDTH must be 32)
//   undefined : data_reg captures raw mem_rdata, load_funct3/load_addr_lo are
//               ignored and load_err comes only from the timeout
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   alu_result   in   combinational ALU output
//   alu_en       in   alu_out register captures alu_result when 1
//   pc_plus4     in   PC+4 for JAL/JALR link
//   load_start   in   1-cycle load request
//   load_funct3  in   load type, sampled with load_start
//   load_addr_lo in   address bits [1:0], sampled with load_start
//   mem_rdata    in   memory read data
//   mem_rvalid   in   mem_rdata valid this cycle
//   result_sel   in   0 alu_out, 1 data_reg, 2 alu_result, 3 pc_plus4
//   result       out  selected writeback value
//   load_busy    out  high while waiting for load data
//   load_done    out  1-cycle pulse: data_reg updated
//   load_err     out  1-cycle pulse: timeout or misaligned request
// -----------------------------------------------------------------------------
module result_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_en,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic             load_start,
    input  logic [2:0]       load_funct3,
    input  logic [1:0]       load_addr_lo,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_rvalid,
    input  logic [1:0]       result_sel,
    output logic [WIDTH-1:0] result,
    output logic             load_busy,
    output logic             load_done,
    output logic             load_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t           state;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] data_reg;
    logic [7:0]       cnt;
    logic [7:0]       cnt_next;
    logic [WIDTH-1:0] load_value;
    logic             misaligned;

`ifdef RESULT_LOAD_EXT_EN
    logic [2:0] funct3_q;
    logic [1:0] addr_lo_q;

    // Pick the addressed lane and extend it according to the load type.
    function automatic logic [WIDTH-1:0] extract(input logic [WIDTH-1:0] rdata,
                                                 input logic [2:0]       f3,
                                                 input logic [1:0]       lo);
        logic signed [7:0]  b_lane;
        logic signed [15:0] h_lane;
        case (lo)
            2'd0:    b_lane = rdata[7:0];
            2'd1:    b_lane = rdata[15:8];
            2'd2:    b_lane = rdata[23:16];
            default: b_lane = rdata[31:24];
        endcase
        h_lane = lo[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  extract = {{(WIDTH-8){b_lane[7]}}, b_lane};
            3'b100:  extract = {{(WIDTH-8){1'b0}}, b_lane};
            3'b001:  extract = {{(WIDTH-16){h_lane[15]}}, h_lane};
            3'b101:  extract = {{(WIDTH-16){1'b0}}, h_lane};
            default: extract = rdata;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] lo);
        is_misaligned = ((f3[1:0] == 2'b01) && lo[0]) ||
                        ((f3 == 3'b010) && (lo != 2'b00));
    endfunction

    assign misaligned = is_misaligned(load_funct3, load_addr_lo);
    assign load_value = extract(mem_rdata, funct3_q, addr_lo_q);
`else
    logic unused_load_info;

    assign unused_load_info = ^{load_funct3, load_addr_lo};
    assign misaligned       = 1'b0;
    assign load_value       = mem_rdata;
`endif

    // Saturating increment: the counter never wraps back to zero.
    assign cnt_next  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign load_busy = (state == S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= '0;
        end else if (alu_en) begin
            alu_out <= alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            data_reg  <= '0;
            cnt       <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
`ifdef RESULT_LOAD_EXT_EN
            funct3_q  <= '0;
            addr_lo_q <= '0;
`endif
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        if (misaligned) begin
                            load_err <= 1'b1;
                        end else begin
`ifdef RESULT_LOAD_EXT_EN
                            funct3_q  <= load_funct3;
                            addr_lo_q <= load_addr_lo;
`endif
                            cnt   <= '0;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Data arriving in the timeout cycle still completes the load.
                    if (mem_rvalid) begin
                        data_reg  <= load_value;
                        load_done <= 1'b1;
                        state     <= S_IDLE;
                    end else if (cnt_next == TIMEOUT_CNT) begin
                        cnt      <= cnt_next;
                        load_err <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        result = alu_out;
        case (result_sel)
            2'd0:    result = alu_out;
            2'd1:    result = data_reg;
            2'd2:    result = alu_result;
            default: result = pc_plus4;
        endcase
    end

endmodule

// File: tb/tb_result_stage.sv
// -----------------------------------------------------------------------------
// tb_result_stage
//
// Directed testbench for result_stage. Expected values depend on whether
// RESULT_LOAD_EXT_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_result_stage;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] alu_result;
    logic             alu_en;
    logic [WIDTH-1:0] pc_plus4;
    logic             load_start;
    logic [2:0]       load_funct3;
    logic [1:0]       load_addr_lo;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_rvalid;
    logic [1:0]       result_sel;
    logic [WIDTH-1:0] result;
    logic             load_busy;
    logic             load_done;
    logic             load_err;

    int checks = 0;
    int errors = 0;

    result_stage #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_result   (alu_result),
        .alu_en       (alu_en),
        .pc_plus4     (pc_plus4),
        .load_start   (load_start),
        .load_funct3  (load_funct3),
        .load_addr_lo (load_addr_lo),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .result_sel   (result_sel),
        .result       (result),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle load request; returns just after the sampling edge.
    task automatic issue_load(input logic [2:0] f3, input logic [1:0] lo);
        load_funct3  = f3;
        load_addr_lo = lo;
        load_start   = 1'b1;
        step();
        load_start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_result = '0; alu_en = 1'b0; pc_plus4 = 32'h0000_1004;
        load_start = 1'b0; load_funct3 = '0; load_addr_lo = '0;
        mem_rdata = '0; mem_rvalid = 1'b0; result_sel = 2'd0;
        step();
        step();
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_alu_out got %h want %h", result, 32'h0); end
        result_sel = 2'd1; #1;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_data_reg got %h want %h", result, 32'h0); end
        checks++; if ({load_busy, load_done, load_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {load_busy, load_done, load_err}); end
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        alu_result = 32'h0000_1234; alu_en = 1'b1;
        step();
        alu_result = 32'hDEAD_BEEF; alu_en = 1'b0;
        step();
        result_sel = 2'd0; #1;
        checks++; if (result !== 32'h0000_1234) begin errors++; $display("FAIL alu_out_hold got %h want %h", result, 32'h0000_1234); end
        result_sel = 2'd2; #1;
        checks++; if (result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_bypass got %h want %h", result, 32'hDEAD_BEEF); end
        result_sel = 2'd3; #1;
        checks++; if (result !== 32'h0000_1004) begin errors++; $display("FAIL pc_plus4 got %h want %h", result, 32'h0000_1004); end
        result_sel = 2'd1;
    endtask

    task automatic test_load_byte();
        logic [31:0] exp_lb;
        logic [31:0] exp_lbu;
`ifdef RESULT_LOAD_EXT_EN
        exp_lb  = 32'hFFFF_FF80;
        exp_lbu = 32'h0000_0080;
`else
        exp_lb  = 32'h1280_FF34;
        exp_lbu = 32'h1280_FF34;
`endif
        mem_rdata = 32'h1280_FF34;
        issue_load(3'b000, 2'd2);
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL lb_busy1 got %b want 1", load_busy); end
        step();
        checks++; if ({load_busy, load_done} !== 2'b10) begin errors++; $display("FAIL lb_busy2 got %b want 10", {load_busy, load_done}); end
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({load_busy, load_done, load_err} !== 3'b010) begin errors++; $display("FAIL lb_done got %b want 010", {load_busy, load_done, load_err}); end
        checks++; if (result !== exp_lb) begin errors++; $display("FAIL lb_data got %h want %h", result, exp_lb); end
        step();
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL lb_done_pulse got %b want 0", load_done); end

        issue_load(3'b100, 2'd2);
        step();
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL lbu_done got %b want 1", load_done); end
        checks++; if (result !== exp_lbu) begin errors++; $display("FAIL lbu_data got %h want %h", result, exp_lbu); end
        step();
    endtask

    task automatic test_half_misaligned();
        logic [31:0] exp_lh;
`ifdef RESULT_LOAD_EXT_EN
        exp_lh = 32'hFFFF_8001;
`else
        exp_lh = 32'h8001_7FFF;
`endif
        mem_rdata = 32'h8001_7FFF;
        issue_load(3'b001, 2'd2);
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++; if (result !== exp_lh) begin errors++; $display("FAIL lh_data got %h want %h", result, exp_lh); end
        step();

        mem_rdata = 32'h1357_9BDF;
        issue_load(3'b001, 2'd1);
`ifdef RESULT_LOAD_EXT_EN
        checks++; if ({load_busy, load_done, load_err} !== 3'b001) begin errors++; $display("FAIL misaligned_err got %b want 001", {load_busy, load_done, load_err}); end
        step();
        checks++; if ({load_busy, load_err} !== 2'b00) begin errors++; $display("FAIL misaligned_pulse got %b want 00", {load_busy, load_err}); end
        // Data presented while idle must not be captured.
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++; if (result !== exp_lh) begin errors++; $display("FAIL misaligned_hold got %h want %h", result, exp_lh); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL idle_rvalid_done got %b want 0", load_done); end
`else
        checks++; if ({load_busy, load_err} !== 2'b10) begin errors++; $display("FAIL raw_no_misalign got %b want 10", {load_busy, load_err}); end
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++; if (result !== 32'h1357_9BDF) begin errors++; $display("FAIL raw_odd_addr got %h want %h", result, 32'h1357_9BDF); end
        // Data presented while idle must not be captured.
        mem_rdata  = 32'h0BAD_0BAD;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++; if (result !== 32'h1357_9BDF) begin errors++; $display("FAIL idle_rvalid_hold got %h want %h", result, 32'h1357_9BDF); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL idle_rvalid_done got %b want 0", load_done); end
`endif
        step();
    endtask

    task automatic test_timeout();
        logic [31:0] held;
        int          busy_cycles;
        held = result;
        mem_rdata = 32'hFFFF_FFFF;
        issue_load(3'b010, 2'd0);
        busy_cycles = 0;
        while (load_busy && busy_cycles < 40) begin
            busy_cycles++;
            checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL timeout_early_err cycle %0d got %b want 0", busy_cycles, load_err); end
            step();
        end
        checks++; if (busy_cycles != TIMEOUT) begin errors++; $display("FAIL timeout_busy_len got %0d want %0d", busy_cycles, TIMEOUT); end
        checks++; if ({load_done, load_err} !== 2'b01) begin errors++; $display("FAIL timeout_err got %b want 01", {load_done, load_err}); end
        checks++; if (result !== held) begin errors++; $display("FAIL timeout_hold got %h want %h", result, held); end
        step();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL timeout_single_pulse got %b want 0", load_err); end

        // Data arriving in the last allowed cycle wins over the timeout.
        mem_rdata = 32'hA5A5_5A5A;
        issue_load(3'b010, 2'd0);
        repeat (TIMEOUT - 1) step();
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL late_still_busy got %b want 1", load_busy); end
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({load_busy, load_done, load_err} !== 3'b010) begin errors++; $display("FAIL late_rvalid got %b want 010", {load_busy, load_done, load_err}); end
        checks++; if (result !== 32'hA5A5_5A5A) begin errors++; $display("FAIL late_rvalid_data got %h want %h", result, 32'hA5A5_5A5A); end
        step();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL late_no_err got %b want 0", load_err); end
    endtask

    task automatic test_reset_mid_wait();
        issue_load(3'b010, 2'd0);
        // A second request while waiting is ignored.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        checks++; if ({load_busy, load_done, load_err} !== 3'b100) begin errors++; $display("FAIL start_in_wait got %b want 100", {load_busy, load_done, load_err}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({load_busy, load_done, load_err} !== 3'b000) begin errors++; $display("FAIL async_reset_flags got %b want 000", {load_busy, load_done, load_err}); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL async_reset_data got %h want %h", result, 32'h0); end
        step();
        #2 rst_n = 1'b1;
        step();
        checks++; if ({load_busy, load_done, load_err} !== 3'b000) begin errors++; $display("FAIL post_reset_flags got %b want 000", {load_busy, load_done, load_err}); end
        result_sel = 2'd0; #1;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL post_reset_alu_out got %h want %h", result, 32'h0); end
        result_sel = 2'd1;
    endtask

    task automatic test_raw_word();
        logic [31:0] exp_v;
`ifdef RESULT_LOAD_EXT_EN
        exp_v = 32'h0000_000D;
`else
        exp_v = 32'hCAFE_F00D;
`endif
        mem_rdata = 32'hCAFE_F00D;
        issue_load(3'b000, 2'd0);
        step();
        step();
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL raw_done got %b want 1", load_done); end
        checks++; if (result !== exp_v) begin errors++; $display("FAIL raw_data got %h want %h", result, exp_v); end
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_half_misaligned();
        test_timeout();
        test_reset_mid_wait();
        test_raw_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
